// File: rtl/lbuf_pingpong.sv
// Double-buffered, self-clearing sprite line buffer: back bank is written, front bank is read-and-cleared.
// Optional macro LBUF_PRIO_EN turns writes into a 2-stage read-modify-write where the first opaque pixel wins.
module lbuf_pingpong #(
    parameter int              AW     = 9,
    parameter int              DW     = 8,
    parameter logic [DW-1:0]   TRANSP = '0
) (
    input  logic          CL,
    input  logic          RST,
    input  logic          SWAP,
    input  logic          WEN,
    input  logic [AW-1:0] WAD,
    input  logic [DW-1:0] WDI,
    input  logic          REN,
    input  logic [AW-1:0] RAD,
    output logic [DW-1:0] RDO,
    output logic          BANK,
    output logic          BUSY
);

    localparam int DEPTH = 2 ** AW;

    typedef enum logic {ST_INIT, ST_RUN} state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] cnt_q, cnt_d;
    logic          bank_q, bank_d;
    logic [DW-1:0] rdo_q, rdo_d;

    logic [DW-1:0] mem [2][DEPTH];

    logic          run;
    logic          clr_all;
    logic          back_bank;
    logic          wr_en;
    logic          wr_bank;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;

    assign run       = (state_q == ST_RUN) && !RST;
    assign clr_all   = (state_q == ST_INIT) && !RST;
    assign back_bank = ~bank_q;

    // Control: clear sequencer, bank select and registered read port
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bank_d  = bank_q;
        rdo_d   = rdo_q;
        if (state_q == ST_INIT) begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == '1) begin
                state_d = ST_RUN;
            end
        end else begin
            if (SWAP) begin
                bank_d = ~bank_q;
            end
            if (REN) begin
                rdo_d = mem[bank_q][RAD];
            end
        end
    end

    always_ff @(posedge CL) begin
        if (RST) begin
            state_q <= ST_INIT;
            cnt_q   <= '0;
            bank_q  <= 1'b0;
            rdo_q   <= TRANSP;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bank_q  <= bank_d;
            rdo_q   <= rdo_d;
        end
    end

`ifdef LBUF_PRIO_EN
    logic          wp_vld_q, wp_vld_d;
    logic          wp_bank_q, wp_bank_d;
    logic [AW-1:0] wp_addr_q, wp_addr_d;
    logic [DW-1:0] wp_data_q, wp_data_d;
    logic [DW-1:0] wp_old_q, wp_old_d;
    logic          wp_wr;
    logic          fwd_hit;

    // Stage 1: capture the current back-bank value, forwarding a stage-2 result to the same location
    always_comb begin
        wp_wr     = wp_vld_q && (wp_old_q == TRANSP);
        fwd_hit   = wp_vld_q && (wp_bank_q == back_bank) && (wp_addr_q == WAD);
        wp_vld_d  = run && WEN && (WDI != TRANSP);
        wp_bank_d = back_bank;
        wp_addr_d = WAD;
        wp_data_d = WDI;
        wp_old_d  = mem[back_bank][WAD];
        if (fwd_hit) begin
            wp_old_d = wp_wr ? wp_data_q : wp_old_q;
        end
    end

    always_ff @(posedge CL) begin
        if (RST) begin
            wp_vld_q <= 1'b0;
        end else begin
            wp_vld_q <= wp_vld_d;
        end
    end

    always_ff @(posedge CL) begin
        wp_bank_q <= wp_bank_d;
        wp_addr_q <= wp_addr_d;
        wp_data_q <= wp_data_d;
        wp_old_q  <= wp_old_d;
    end

    // Stage 2: bank captured at issue time, so a swap in between does not redirect the write
    assign wr_en   = wp_wr && !RST;
    assign wr_bank = wp_bank_q;
    assign wr_addr = wp_addr_q;
    assign wr_data = wp_data_q;
`else
    assign wr_en   = run && WEN && (WDI != TRANSP);
    assign wr_bank = back_bank;
    assign wr_addr = WAD;
    assign wr_data = WDI;
`endif

    // Storage: sequencer clear, sprite write, and read-clear of the front location
    always_ff @(posedge CL) begin
        if (clr_all) begin
            mem[0][cnt_q] <= TRANSP;
            mem[1][cnt_q] <= TRANSP;
        end else begin
            if (wr_en) begin
                mem[wr_bank][wr_addr] <= wr_data;
            end
            if (run && REN) begin
                mem[bank_q][RAD] <= TRANSP;
            end
        end
    end

    assign RDO  = rdo_q;
    assign BANK = bank_q;
    assign BUSY = (state_q == ST_INIT);

endmodule

// File: tb/tb_lbuf_pingpong.sv
// Directed, table-driven bench for lbuf_pingpong (default parameters); honours LBUF_PRIO_EN when defined.
module tb_lbuf_pingpong;

    localparam int AW = 9;
    localparam int DW = 8;

    logic          CL = 1'b0;
    logic          RST;
    logic          SWAP;
    logic          WEN;
    logic [AW-1:0] WAD;
    logic [DW-1:0] WDI;
    logic          REN;
    logic [AW-1:0] RAD;
    logic [DW-1:0] RDO;
    logic          BANK;
    logic          BUSY;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic          sw;
        logic          we;
        logic [AW-1:0] wa;
        logic [DW-1:0] wd;
        logic          re;
        logic [AW-1:0] ra;
        logic          ck;
        logic [DW-1:0] rdo;
        logic          bank;
    } vec_t;

    vec_t tbl[$];

    lbuf_pingpong #(.AW(AW), .DW(DW), .TRANSP(8'h00)) dut (
        .CL   (CL),
        .RST  (RST),
        .SWAP (SWAP),
        .WEN  (WEN),
        .WAD  (WAD),
        .WDI  (WDI),
        .REN  (REN),
        .RAD  (RAD),
        .RDO  (RDO),
        .BANK (BANK),
        .BUSY (BUSY)
    );

    always #5 CL = ~CL;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic sw, input logic we, input logic [AW-1:0] wa,
                         input logic [DW-1:0] wd, input logic re, input logic [AW-1:0] ra);
        SWAP = sw;
        WEN  = we;
        WAD  = wa;
        WDI  = wd;
        REN  = re;
        RAD  = ra;
        @(posedge CL);
        #1;
    endtask

    task automatic add(input logic sw, input logic we, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                       input logic re, input logic [AW-1:0] ra, input logic ck, input logic [DW-1:0] rdo,
                       input logic bank);
        vec_t v;
        v.sw = sw; v.we = we; v.wa = wa; v.wd = wd; v.re = re; v.ra = ra;
        v.ck = ck; v.rdo = rdo; v.bank = bank;
        tbl.push_back(v);
    endtask

    task automatic wait_clear(input string nm);
        int cnt;
        cnt = 0;
        while (BUSY === 1'b1 && cnt < 2000) begin
            @(posedge CL);
            #1;
            cnt++;
        end
        chk(nm, cnt, 512);
    endtask

    initial begin
        logic [DW-1:0] exp_pri;
`ifdef LBUF_PRIO_EN
        exp_pri = 8'h41;
`else
        exp_pri = 8'h42;
`endif
        RST = 1'b1;
        drive(1'b0, 1'b0, 9'd0, 8'h00, 1'b0, 9'd0);
        drive(1'b0, 1'b0, 9'd0, 8'h00, 1'b0, 9'd0);
        chk("rst_rdo", RDO, 8'h00);
        chk("rst_bank", BANK, 1'b0);
        chk("rst_busy", BUSY, 1'b1);

        // Release with SWAP/WEN/REN asserted throughout the clear; all must be ignored.
        RST  = 1'b0;
        SWAP = 1'b1; WEN = 1'b1; WAD = 9'd5; WDI = 8'h55; REN = 1'b1; RAD = 9'd5;
        wait_clear("busy_len_init");
        SWAP = 1'b0; WEN = 1'b0; REN = 1'b0;
        chk("init_bank", BANK, 1'b0);
        chk("init_rdo", RDO, 8'h00);

        for (int a = 0; a < 512; a++) begin
            drive(1'b0, 1'b0, 9'd0, 8'h00, 1'b1, a[AW-1:0]);
            chk("sweep_b0", RDO, 8'h00);
        end
        drive(1'b1, 1'b0, 9'd0, 8'h00, 1'b0, 9'd0);
        chk("sweep_swap_bank", BANK, 1'b1);
        for (int a = 0; a < 512; a++) begin
            drive(1'b0, 1'b0, 9'd0, 8'h00, 1'b1, a[AW-1:0]);
            chk("sweep_b1", RDO, 8'h00);
        end

        //  sw    we    wa     wd     re    ra     ck    rdo    bank
        add(1'b0, 1'b1, 9'd5,  8'h3C, 1'b0, 9'd0,  1'b0, 8'h00, 1'b1);
        add(1'b1, 1'b0, 9'd0,  8'h00, 1'b0, 9'd0,  1'b0, 8'h00, 1'b0);
        add(1'b0, 1'b0, 9'd0,  8'h00, 1'b1, 9'd5,  1'b1, 8'h3C, 1'b0);
        add(1'b0, 1'b0, 9'd0,  8'h00, 1'b1, 9'd5,  1'b1, 8'h00, 1'b0);
        add(1'b0, 1'b1, 9'd7,  8'h11, 1'b0, 9'd0,  1'b0, 8'h00, 1'b0);
        add(1'b0, 1'b1, 9'd7,  8'h00, 1'b0, 9'd0,  1'b0, 8'h00, 1'b0);
        add(1'b1, 1'b0, 9'd0,  8'h00, 1'b0, 9'd0,  1'b0, 8'h00, 1'b1);
        add(1'b0, 1'b0, 9'd0,  8'h00, 1'b1, 9'd7,  1'b1, 8'h11, 1'b1);
        add(1'b0, 1'b0, 9'd0,  8'h00, 1'b0, 9'd7,  1'b1, 8'h11, 1'b1);
        add(1'b0, 1'b0, 9'd0,  8'h00, 1'b1, 9'd7,  1'b1, 8'h00, 1'b1);
        add(1'b0, 1'b1, 9'd3,  8'h5A, 1'b0, 9'd0,  1'b0, 8'h00, 1'b1);
        add(1'b1, 1'b0, 9'd0,  8'h00, 1'b0, 9'd0,  1'b0, 8'h00, 1'b0);
        add(1'b1, 1'b1, 9'd3,  8'h22, 1'b1, 9'd3,  1'b1, 8'h5A, 1'b1);
        add(1'b0, 1'b0, 9'd0,  8'h00, 1'b0, 9'd0,  1'b1, 8'h5A, 1'b1);
        add(1'b0, 1'b0, 9'd0,  8'h00, 1'b1, 9'd3,  1'b1, 8'h22, 1'b1);
        add(1'b0, 1'b0, 9'd0,  8'h00, 1'b1, 9'd3,  1'b1, 8'h00, 1'b1);
        add(1'b1, 1'b0, 9'd0,  8'h00, 1'b0, 9'd0,  1'b0, 8'h00, 1'b0);
        add(1'b0, 1'b0, 9'd0,  8'h00, 1'b1, 9'd3,  1'b1, 8'h00, 1'b0);
        add(1'b0, 1'b1, 9'd20, 8'h77, 1'b0, 9'd0,  1'b0, 8'h00, 1'b0);
        add(1'b0, 1'b0, 9'd0,  8'h00, 1'b1, 9'd20, 1'b1, 8'h00, 1'b0);
        add(1'b1, 1'b0, 9'd0,  8'h00, 1'b0, 9'd0,  1'b0, 8'h00, 1'b1);
        add(1'b0, 1'b0, 9'd0,  8'h00, 1'b1, 9'd20, 1'b1, 8'h77, 1'b1);

        foreach (tbl[i]) begin
            drive(tbl[i].sw, tbl[i].we, tbl[i].wa, tbl[i].wd, tbl[i].re, tbl[i].ra);
            chk($sformatf("vec%0d_bank", i), BANK, tbl[i].bank);
            if (tbl[i].ck) begin
                chk($sformatf("vec%0d_rdo", i), RDO, tbl[i].rdo);
            end
        end

        // Back-to-back writes to one address: first wins with priority, last wins without.
        drive(1'b0, 1'b1, 9'd9, 8'h41, 1'b0, 9'd0);
        drive(1'b0, 1'b1, 9'd9, 8'h42, 1'b0, 9'd0);
        drive(1'b1, 1'b0, 9'd0, 8'h00, 1'b0, 9'd0);
        drive(1'b0, 1'b0, 9'd0, 8'h00, 1'b1, 9'd9);
        chk("prio_rdo", RDO, exp_pri);
        chk("prio_bank", BANK, 1'b0);

        // Leave BANK=1, RDO opaque and a pending back-bank pixel before resetting.
        drive(1'b1, 1'b0, 9'd0, 8'h00, 1'b0, 9'd0);
        drive(1'b0, 1'b1, 9'd33, 8'h66, 1'b0, 9'd0);
        drive(1'b0, 1'b0, 9'd0, 8'h00, 1'b0, 9'd0);
        drive(1'b0, 1'b0, 9'd0, 8'h00, 1'b0, 9'd0);
        chk("pre_rst_bank", BANK, 1'b1);
        RST = 1'b1;
        drive(1'b0, 1'b0, 9'd0, 8'h00, 1'b0, 9'd0);
        chk("rst2_rdo", RDO, 8'h00);
        chk("rst2_bank", BANK, 1'b0);
        chk("rst2_busy", BUSY, 1'b1);

        RST = 1'b0;
        for (int k = 0; k < 100; k++) begin
            drive(1'b0, 1'b0, 9'd0, 8'h00, 1'b0, 9'd0);
        end
        chk("mid_init_busy", BUSY, 1'b1);
        RST = 1'b1;
        drive(1'b0, 1'b0, 9'd0, 8'h00, 1'b0, 9'd0);
        RST = 1'b0;
        wait_clear("busy_len_mid");
        chk("mid_bank", BANK, 1'b0);
        chk("mid_rdo", RDO, 8'h00);
        drive(1'b0, 1'b0, 9'd0, 8'h00, 1'b1, 9'd33);
        chk("cleared_33", RDO, 8'h00);
        drive(1'b1, 1'b0, 9'd0, 8'h00, 1'b0, 9'd0);
        drive(1'b0, 1'b0, 9'd0, 8'h00, 1'b1, 9'd20);
        chk("cleared_b1_20", RDO, 8'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
